alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Four-state instruction sequencer that decodes opcode/funct into a registered ALU control code.
// Optional feature: define ALU_SEQ_ILLEGAL_TRAP_EN to flag unlisted encodings on illegal_op during DONE.
module alu_seq_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [5:0] alu_control_out,
    output logic       busy,
    output logic       done,
    output logic       reg_write,
    output logic       branch_taken,
    output logic       illegal_op
);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_DECODE = 2'b01;
    localparam logic [1:0] S_EXEC   = 2'b10;
    localparam logic [1:0] S_DONE   = 2'b11;

    // Result packing: {legal, branch, code[5:0]}; unlisted encodings yield all zeros.
    function automatic logic [7:0] decode_op(input logic [5:0] op, input logic [5:0] fn);
        logic [7:0] d;
        d = 8'h00;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000: d = {2'b10, 6'b000000};
                    6'b100010: d = {2'b10, 6'b000001};
                    6'b100100: d = {2'b10, 6'b000010};
                    6'b100111: d = {2'b10, 6'b000011};
                    6'b100101: d = {2'b10, 6'b000100};
                    6'b101010: d = {2'b10, 6'b000101};
                    default:   d = 8'h00;
                endcase
            end
            6'b001000: d = {2'b10, 6'b000110};
            6'b001100: d = {2'b10, 6'b000111};
            6'b011000: d = {2'b10, 6'b001000};
            6'b001101: d = {2'b10, 6'b001001};
            6'b001010: d = {2'b10, 6'b001101};
            6'b000100: d = {2'b11, 6'b001010};
            6'b000101: d = {2'b11, 6'b001011};
            6'b000001: d = {2'b11, 6'b001100};
            default:   d = 8'h00;
        endcase
        return d;
    endfunction

    logic [1:0] r_state;
    logic [5:0] r_opcode;
    logic [5:0] r_funct;
    logic [5:0] r_alu_ctrl;
    logic       r_busy;
    logic       r_done;
    logic       r_reg_write;
    logic       r_branch_taken;
    logic       r_illegal_op;

    logic [1:0] w_next_state;
    logic [7:0] w_dec;
    logic       w_legal;
    logic       w_branch;

    assign w_dec    = decode_op(r_opcode, r_funct);
    assign w_legal  = w_dec[7];
    assign w_branch = w_dec[6];

    // Next-state selection; start only matters while idle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC:   w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // State register and instruction latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_opcode <= 6'b000000;
            r_funct  <= 6'b000000;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && start) begin
                r_opcode <= opcode;
                r_funct  <= funct;
            end
        end
    end

    // Status outputs are registered so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_ctrl     <= 6'b000000;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_reg_write    <= 1'b0;
            r_branch_taken <= 1'b0;
            r_illegal_op   <= 1'b0;
        end else begin
            r_busy <= (w_next_state != S_IDLE);
            r_done <= (w_next_state == S_DONE);
            if (r_state == S_DECODE) begin
                r_alu_ctrl <= w_dec[5:0];
            end
            // zero is captured on the EXEC-to-DONE edge.
            r_reg_write    <= (r_state == S_EXEC) && w_legal && !w_branch;
            r_branch_taken <= (r_state == S_EXEC) && w_legal && w_branch && zero;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            r_illegal_op   <= (r_state == S_EXEC) && !w_legal;
`else
            r_illegal_op   <= 1'b0;
`endif
        end
    end

    assign alu_control_out = r_alu_ctrl;
    assign busy            = r_busy;
    assign done            = r_done;
    assign reg_write       = r_reg_write;
    assign branch_taken    = r_branch_taken;
    assign illegal_op      = r_illegal_op;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl; honours ALU_SEQ_ILLEGAL_TRAP_EN for illegal_op expectations.
module tb_alu_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [5:0] alu_control_out;
    logic       busy;
    logic       done;
    logic       reg_write;
    logic       branch_taken;
    logic       illegal_op;

    int n_checks;
    int n_fail;
    logic exp_ill;

    alu_seq_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .opcode          (opcode),
        .funct           (funct),
        .zero            (zero),
        .alu_control_out (alu_control_out),
        .busy            (busy),
        .done            (done),
        .reg_write       (reg_write),
        .branch_taken    (branch_taken),
        .illegal_op      (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full instruction: IDLE accept, DECODE, EXEC, DONE, back to IDLE.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic [5:0] exp_code,
                             input logic exp_rw, input logic exp_bt, input logic exp_il);
        @(negedge clk);
        start = 1'b1; opcode = op; funct = fn; zero = ~z;
        @(negedge clk);
        start = 1'b0; opcode = ~op; funct = ~fn;
        check_eq({name, "/dec_busy"}, {7'd0, busy}, 8'd1);
        check_eq({name, "/dec_done"}, {7'd0, done}, 8'd0);
        @(negedge clk);
        zero = z;
        check_eq({name, "/exec_code"}, {2'd0, alu_control_out}, {2'd0, exp_code});
        check_eq({name, "/exec_done"}, {7'd0, done}, 8'd0);
        check_eq({name, "/exec_rw"}, {7'd0, reg_write}, 8'd0);
        @(negedge clk);
        zero = ~z;
        check_eq({name, "/done"}, {7'd0, done}, 8'd1);
        check_eq({name, "/done_rw"}, {7'd0, reg_write}, {7'd0, exp_rw});
        check_eq({name, "/done_bt"}, {7'd0, branch_taken}, {7'd0, exp_bt});
        check_eq({name, "/done_ill"}, {7'd0, illegal_op}, {7'd0, exp_il});
        @(negedge clk);
        check_eq({name, "/idle_busy"}, {7'd0, busy}, 8'd0);
        check_eq({name, "/idle_done"}, {7'd0, done}, 8'd0);
        check_eq({name, "/idle_flags"}, {5'd0, reg_write, branch_taken, illegal_op}, 8'd0);
        check_eq({name, "/idle_hold"}, {2'd0, alu_control_out}, {2'd0, exp_code});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        reset = 1'b1; start = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
        #3;
        check_eq("rst_async", {alu_control_out, busy, done},
                 8'd0);
        check_eq("rst_flags", {5'd0, reg_write, branch_taken, illegal_op}, 8'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // First accepted instruction right after reset: SUB.
        run_instr("sub", 6'b000000, 6'b100010, 1'b0, 6'b000001, 1'b1, 1'b0, 1'b0);

        // Branches with zero set and clear.
        run_instr("beq_z1", 6'b000100, 6'b000000, 1'b1, 6'b001010, 1'b0, 1'b1, 1'b0);
        run_instr("beq_z0", 6'b000100, 6'b000000, 1'b0, 6'b001010, 1'b0, 1'b0, 1'b0);

        // Sweep of the remaining legal encodings.
        run_instr("add",  6'b000000, 6'b100000, 1'b1, 6'b000000, 1'b1, 1'b0, 1'b0);
        run_instr("and",  6'b000000, 6'b100100, 1'b1, 6'b000010, 1'b1, 1'b0, 1'b0);
        run_instr("nor",  6'b000000, 6'b100111, 1'b0, 6'b000011, 1'b1, 1'b0, 1'b0);
        run_instr("or",   6'b000000, 6'b100101, 1'b1, 6'b000100, 1'b1, 1'b0, 1'b0);
        run_instr("slt",  6'b000000, 6'b101010, 1'b0, 6'b000101, 1'b1, 1'b0, 1'b0);
        run_instr("addi", 6'b001000, 6'b010101, 1'b1, 6'b000110, 1'b1, 1'b0, 1'b0);
        run_instr("andi", 6'b001100, 6'b000000, 1'b0, 6'b000111, 1'b1, 1'b0, 1'b0);
        run_instr("subi", 6'b011000, 6'b100010, 1'b1, 6'b001000, 1'b1, 1'b0, 1'b0);
        run_instr("ori",  6'b001101, 6'b000000, 1'b0, 6'b001001, 1'b1, 1'b0, 1'b0);
        run_instr("slti", 6'b001010, 6'b000000, 1'b1, 6'b001101, 1'b1, 1'b0, 1'b0);
        run_instr("bneq", 6'b000101, 6'b000000, 1'b1, 6'b001011, 1'b0, 1'b1, 1'b0);
        run_instr("bgez", 6'b000001, 6'b000000, 1'b0, 6'b001100, 1'b0, 1'b0, 1'b0);

        // Unlisted encodings.
        run_instr("ill_op", 6'b111111, 6'b000000, 1'b1, 6'b000000, 1'b0, 1'b0, exp_ill);
        run_instr("ill_fn", 6'b000000, 6'b000111, 1'b1, 6'b000000, 1'b0, 1'b0, exp_ill);

        // start held high: ORI then SLTI, 4-cycle issue interval.
        @(negedge clk);
        start = 1'b1; opcode = 6'b001101; funct = 6'd0; zero = 1'b0;
        @(negedge clk);
        opcode = 6'b001010;
        check_eq("b2b_dec1_busy", {7'd0, busy}, 8'd1);
        @(negedge clk);
        check_eq("b2b_exec1_code", {2'd0, alu_control_out}, 8'h09);
        @(negedge clk);
        check_eq("b2b_done1", {7'd0, done}, 8'd1);
        @(negedge clk);
        check_eq("b2b_idle_busy", {6'd0, busy, done}, 8'd0);
        @(negedge clk);
        opcode = 6'b001000;
        check_eq("b2b_dec2_busy", {6'd0, busy, done}, 8'd2);
        @(negedge clk);
        start = 1'b0;
        check_eq("b2b_exec2_code", {2'd0, alu_control_out}, 8'h0d);
        @(negedge clk);
        check_eq("b2b_done2", {6'd0, done, reg_write}, 8'd3);
        @(negedge clk);
        check_eq("b2b_end_busy", {7'd0, busy}, 8'd0);
        check_eq("b2b_end_code", {2'd0, alu_control_out}, 8'h0d);

        // Reset during EXEC of ADDI aborts the instruction.
        @(negedge clk);
        start = 1'b1; opcode = 6'b001000; funct = 6'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("abort_exec_code", {2'd0, alu_control_out}, 8'h06);
        #2;
        reset = 1'b1;
        #1;
        check_eq("abort_async", {alu_control_out, busy, done}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("abort_no_done", {5'd0, done, reg_write, busy}, 8'd0);
        end
        run_instr("post_rst", 6'b001000, 6'b000000, 1'b0, 6'b000110, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
